// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the synch_fifo burst reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_BURST = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry fall-through skid buffer carrying a data word plus its last tag.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              fifo_clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        cnt
);

  logic [DATA_W:0] ent0;
  logic [DATA_W:0] ent1;
  logic [DATA_W:0] din;

  assign din = {push_data, push_last};

  always_ff @(posedge fifo_clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge fifo_clk) begin
    case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) ent0 <= din;
        else             ent1 <= din;
      end
      2'b01: ent0 <= ent1;
      2'b11: begin
        if (cnt == 2'd1) begin
          ent0 <= din;
        end else begin
          ent0 <= ent1;
          ent1 <= din;
        end
      end
      default: ;
    endcase
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = out_valid ? ent0[DATA_W:1] : '0;
  assign out_last  = out_valid & ent0[0];

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader draining synch_fifo onto a valid/ready stream with out_last per burst.
// Optional feature: define RD_WORD_CNT_EN to add the rd_word_cnt accepted-word counter.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 32,
  parameter int FIFO_PTR   = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
`ifdef RD_WORD_CNT_EN
  output logic [15:0]           rd_word_cnt,
`endif
  output logic                  busy
);

  localparam logic [FIFO_PTR:0] BURST_W = (FIFO_PTR + 1)'(BURST_LEN);
  localparam logic [FIFO_PTR:0] ONE_W   = (FIFO_PTR + 1)'(1);

  rd_state_t         state;
  logic [FIFO_PTR:0] remaining;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        skid_cnt;
  logic              pop;
  logic [2:0]        occ;

  assign pop  = out_valid && out_ready;
  // Words already committed to the skid once this cycle's pop retires.
  assign occ  = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
  assign fifo_rden = (state == RD_BURST) && (remaining != '0) && !fifo_empty &&
                     (occ < 3'(SKID_DEPTH));
  assign busy = (state != RD_IDLE);

  always_ff @(posedge fifo_clk) begin
    if (!rst) begin
      state     <= RD_IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= fifo_rden;
      case (state)
        RD_IDLE: begin
          if (fifo_data_avail >= BURST_W) begin
            state     <= RD_BURST;
            remaining <= BURST_W;
          end else if (flush && (fifo_data_avail != '0)) begin
            state     <= RD_BURST;
            remaining <= fifo_data_avail;
          end
        end
        RD_BURST: begin
          if (fifo_rden) begin
            remaining <= remaining - ONE_W;
            if (remaining == ONE_W) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if ((skid_cnt == 2'd0) && !inflight) state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  // Last tag follows the read through the FIFO's one-cycle latency.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rden) inflight_last <= (remaining == ONE_W);
  end

  fifo_rd_skid #(
    .DATA_W (FIFO_WIDTH)
  ) u_skid (
    .fifo_clk  (fifo_clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rddata),
    .push_last (inflight_last),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .cnt       (skid_cnt)
  );

`ifdef RD_WORD_CNT_EN
  always_ff @(posedge fifo_clk) begin
    if (!rst) begin
      rd_word_cnt <= '0;
    end else if (pop) begin
      rd_word_cnt <= rd_word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural synch_fifo model.
module tb_fifo_burst_reader;

  localparam int W  = 32;
  localparam int P  = 4;
  localparam int BL = 4;

  logic          fifo_clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [P:0]    fifo_data_avail = '0;
  logic [W-1:0]  fifo_rddata = '0;
  logic          fifo_rden;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;
`ifdef RD_WORD_CNT_EN
  logic [15:0]   rd_word_cnt;
`endif

  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          fifo_clr = 1'b0;
  logic [W-1:0]  mem[$];

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [W-1:0]  acc_data[$];
  logic          acc_last[$];
  int            acc_cyc[$];
  int            rden_cyc[$];
  logic          prv_stall = 1'b0;
  logic [W-1:0]  prv_data = '0;
  logic          prv_last = 1'b0;

  fifo_burst_reader #(
    .FIFO_WIDTH (W),
    .FIFO_PTR   (P),
    .BURST_LEN  (BL)
  ) dut (
    .fifo_clk        (fifo_clk),
    .rst             (rst),
    .fifo_empty      (fifo_empty),
    .fifo_data_avail (fifo_data_avail),
    .fifo_rddata     (fifo_rddata),
    .fifo_rden       (fifo_rden),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_ready       (out_ready),
`ifdef RD_WORD_CNT_EN
    .rd_word_cnt     (rd_word_cnt),
`endif
    .busy            (busy)
  );

  always #5 fifo_clk = ~fifo_clk;

  // synch_fifo model: registered read data, count/empty updated on the clock.
  always @(posedge fifo_clk) begin
    if (fifo_clr) begin
      mem.delete();
    end else begin
      if (fifo_rden && (mem.size() != 0)) fifo_rddata <= mem.pop_front();
      if (wr_en) mem.push_back(wr_data);
    end
    fifo_data_avail <= (P + 1)'(mem.size());
    fifo_empty      <= (mem.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + W'(i);
      @(negedge fifo_clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic check_burst(input string tag, input int base, input logic [W-1:0] first,
                             input int n, input bit consec);
    chk($sformatf("%s_count", tag), 32'(acc_data.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] d;
      logic         l;
      int           c;
      d = 32'hDEAD_BEEF;
      l = 1'bx;
      c = -1;
      if (base + i < acc_data.size()) begin
        d = acc_data[base + i];
        l = acc_last[base + i];
        c = acc_cyc[base + i];
      end
      chk($sformatf("%s_data%0d", tag, i), d, first + W'(i));
      chk($sformatf("%s_last%0d", tag, i), 32'(l),
          32'(((i + 1) % BL == 0) || (i == n - 1)));
      if (consec && i > 0 && base < acc_cyc.size())
        chk($sformatf("%s_gap%0d", tag, i), 32'(c - acc_cyc[base]), 32'(i));
    end
  endtask

  int ba;
  int br;

  initial begin
    fork
      forever begin
        @(negedge fifo_clk);
        #4;
        cyc++;
        chk("skid_cnt_le2", 32'(dut.u_skid.cnt <= 2'd2), 32'd1);
        if (prv_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", out_data, prv_data);
          chk("hold_last", 32'(out_last), 32'(prv_last));
        end
        prv_stall = rst && out_valid && !out_ready;
        prv_data  = out_data;
        prv_last  = out_last;
        if (rst && out_valid && out_ready) begin
          acc_data.push_back(out_data);
          acc_last.push_back(out_last);
          acc_cyc.push_back(cyc);
        end
        if (rst && fifo_rden) rden_cyc.push_back(cyc);
      end
    join_none

    // Reset
    @(negedge fifo_clk);
    rst = 1'b0;
    repeat (2) @(negedge fifo_clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rden", 32'(fifo_rden), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
`ifdef RD_WORD_CNT_EN
    chk("rst_wcnt", 32'(rd_word_cnt), 32'd0);
`endif
    rst = 1'b1;
    @(negedge fifo_clk);
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_rden", 32'(fifo_rden), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // Full burst, streaming
    ba = acc_data.size();
    br = rden_cyc.size();
    out_ready = 1'b1;
    load(32'hA0, 4);
    repeat (12) @(negedge fifo_clk);
    chk("full_rden_cnt", 32'(rden_cyc.size() - br), 32'd4);
    if (rden_cyc.size() >= br + 4)
      chk("full_rden_consec", 32'(rden_cyc[br + 3] - rden_cyc[br]), 32'd3);
    check_burst("full", ba, 32'hA0, 4, 1'b1);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_empty", 32'(fifo_empty), 32'd1);

    // Partial burst only on flush
    ba = acc_data.size();
    br = rden_cyc.size();
    load(32'hB0, 3);
    repeat (20) @(negedge fifo_clk);
    chk("noflush_rden", 32'(rden_cyc.size() - br), 32'd0);
    chk("noflush_busy", 32'(busy), 32'd0);
    flush = 1'b1;
    @(negedge fifo_clk);
    flush = 1'b0;
    repeat (12) @(negedge fifo_clk);
    chk("flush_rden_cnt", 32'(rden_cyc.size() - br), 32'd3);
    check_burst("flush", ba, 32'hB0, 3, 1'b0);
    chk("flush_empty", 32'(fifo_empty), 32'd1);

    // Backpressure
    out_ready = 1'b0;
    ba = acc_data.size();
    br = rden_cyc.size();
    load(32'hC0, 4);
    repeat (10) @(negedge fifo_clk);
    chk("bp_rden_cnt", 32'(rden_cyc.size() - br), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", out_data, 32'hC0);
    chk("bp_last", 32'(out_last), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    repeat (10) @(negedge fifo_clk);
    check_burst("bp", ba, 32'hC0, 4, 1'b1);
    chk("bp_rden_total", 32'(rden_cyc.size() - br), 32'd4);

    // Two back-to-back bursts
    ba = acc_data.size();
    br = rden_cyc.size();
    load(32'hE0, 8);
    repeat (25) @(negedge fifo_clk);
    check_burst("two", ba, 32'hE0, 8, 1'b0);
    chk("two_rden_cnt", 32'(rden_cyc.size() - br), 32'd8);
    chk("two_empty", 32'(fifo_empty), 32'd1);
    chk("two_busy", 32'(busy), 32'd0);

    // Reset mid-burst
    out_ready = 1'b0;
    ba = acc_data.size();
    br = rden_cyc.size();
    load(32'hF0, 4);
    for (int k = 0; k < 20 && (rden_cyc.size() - br) < 2; k++) @(negedge fifo_clk);
    chk("mid_rden_cnt", 32'(rden_cyc.size() - br), 32'd2);
    rst = 1'b0;
    @(negedge fifo_clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rden", 32'(fifo_rden), 32'd0);
`ifdef RD_WORD_CNT_EN
    chk("mid_rst_wcnt", 32'(rd_word_cnt), 32'd0);
`endif
    rst = 1'b1;
    fifo_clr = 1'b1;
    @(negedge fifo_clk);
    fifo_clr = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge fifo_clk);
    chk("mid_no_words", 32'(acc_data.size() - ba), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);
    chk("mid_empty", 32'(fifo_empty), 32'd1);

    // Three full bursts, then word counter reset
    ba = acc_data.size();
    load(32'h100, 12);
    repeat (40) @(negedge fifo_clk);
    check_burst("three", ba, 32'h100, 12, 1'b0);
`ifdef RD_WORD_CNT_EN
    chk("wcnt_12", 32'(rd_word_cnt), 32'd12);
    rst = 1'b0;
    @(negedge fifo_clk);
    chk("wcnt_rst", 32'(rd_word_cnt), 32'd0);
    rst = 1'b1;
    @(negedge fifo_clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
